clint: RTL and testbench

CLINT -- requirements
Module: clint

---
 rtl/clint_pkg.sv | 39 +++
 rtl/clint_if.sv | 15 +
 rtl/clint.sv | 105 ++++++++++
 tb/tb_clint.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clint_pkg.sv
// Shared definitions for the core-local interruptor: register offsets and
// the request/response bundles carried on the CLINT bus.
package constants;

  localparam logic [31:0] clint_msip      = 32'h0000_0000;
  localparam logic [31:0] clint_mtimecmp  = 32'h0000_4000;
  localparam logic [31:0] clint_mtimecmph = 32'h0000_4004;
  localparam logic [31:0] clint_mtime     = 32'h0000_BFF8;
  localparam logic [31:0] clint_mtimeh    = 32'h0000_BFFC;

  // Replace only the bytes of old_val whose enable bit is set.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++)
      if (strb[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
    return res;
  endfunction

endpackage

package wires;

  typedef struct packed {
    logic        valid;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } clint_in_type;

  typedef struct packed {
    logic [31:0] rdata;
    logic        ready;
  } clint_out_type;

endpackage

// File: rtl/clint_if.sv
// CLINT bus: one-cycle request strobe from the core, one-cycle ready pulse back.
interface clint_if;
  logic        clint_valid;
  logic        clint_instr;
  logic [31:0] clint_addr;
  logic [31:0] clint_wdata;
  logic [3:0]  clint_wstrb;
  logic [31:0] clint_rdata;
  logic        clint_ready;

  modport master (output clint_valid, clint_instr, clint_addr, clint_wdata, clint_wstrb,
                  input  clint_rdata, clint_ready);
  modport slave  (input  clint_valid, clint_instr, clint_addr, clint_wdata, clint_wstrb,
                  output clint_rdata, clint_ready);
endinterface

// File: rtl/clint.sv
// Core-local interruptor: free-running 64-bit mtime with prescaler, mtimecmp
// timer compare (mtip) and software interrupt bit (msip), behind a simple bus.
module clint
  import constants::*;
  import wires::*;
#(
  parameter int unsigned RTC_DIV   = 1,
  parameter logic [31:0] BASE_MASK = 32'h0000_FFFF
) (
  input  logic        reset,
  input  logic        clock,
  clint_if.slave      bus,
  output logic        msip,
  output logic        mtip,
  output logic [63:0] mtime
);

  localparam int unsigned    PW       = (RTC_DIV > 1) ? $clog2(RTC_DIV) : 1;
  localparam logic [PW-1:0]  PRE_LAST = PW'(RTC_DIV - 1);

  clint_in_type  req;
  clint_out_type rsp_d, rsp_q;

  logic [PW-1:0] prescale_d, prescale_q;
  logic [63:0]   mtime_d, mtime_q;
  logic [63:0]   mtimecmp_d, mtimecmp_q;
  logic          msip_d, msip_q;
  logic          mtip_d, mtip_q;

  logic [31:0]   offset;
  logic [31:0]   rd_val;
  logic          wr_en;
  logic          tick;

  assign req = '{valid: bus.clint_valid, instr: bus.clint_instr, addr: bus.clint_addr,
                 wdata: bus.clint_wdata, wstrb: bus.clint_wstrb};

  always_comb begin
    offset     = req.addr & BASE_MASK;
    // Fetches are reads even if the strobes happen to be non-zero.
    wr_en      = req.valid && !req.instr && (req.wstrb != 4'b0000);
    tick       = (prescale_q == PRE_LAST);
    prescale_d = tick ? '0 : prescale_q + 1'b1;
    mtime_d    = mtime_q + 64'(tick);
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    rd_val     = '0;

    // A bus write to either mtime half replaces the increment for that cycle.
    case (offset)
      clint_msip: begin
        rd_val = {31'b0, msip_q};
        if (wr_en && req.wstrb[0]) msip_d = req.wdata[0];
      end
      clint_mtimecmp: begin
        rd_val = mtimecmp_q[31:0];
        if (wr_en) mtimecmp_d[31:0] = byte_merge(mtimecmp_q[31:0], req.wdata, req.wstrb);
      end
      clint_mtimecmph: begin
        rd_val = mtimecmp_q[63:32];
        if (wr_en) mtimecmp_d[63:32] = byte_merge(mtimecmp_q[63:32], req.wdata, req.wstrb);
      end
      clint_mtime: begin
        rd_val = mtime_q[31:0];
        if (wr_en) mtime_d = {mtime_q[63:32], byte_merge(mtime_q[31:0], req.wdata, req.wstrb)};
      end
      clint_mtimeh: begin
        rd_val = mtime_q[63:32];
        if (wr_en) mtime_d = {byte_merge(mtime_q[63:32], req.wdata, req.wstrb), mtime_q[31:0]};
      end
      default: ;
    endcase

    rsp_d.ready = req.valid;
    rsp_d.rdata = req.valid ? rd_val : 32'h0;
    mtip_d      = (mtime_q >= mtimecmp_q);
  end

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clock) begin
    if (!reset) begin
      prescale_q <= '0;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      msip_q     <= 1'b0;
      mtip_q     <= 1'b0;
      rsp_q      <= '0;
    end else begin
      prescale_q <= prescale_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      mtip_q     <= mtip_d;
      rsp_q      <= rsp_d;
    end
  end

  assign bus.clint_rdata = rsp_q.rdata;
  assign bus.clint_ready = rsp_q.ready;
  assign msip            = msip_q;
  assign mtip            = mtip_q;
  assign mtime           = mtime_q;

endmodule

// File: tb/tb_clint.sv
// Bench for clint: RTC_DIV=1 instance checked against a cycle model, RTC_DIV=4
// instance checked against elapsed-cycle arithmetic, plus directed literals.
module tb_clint;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  clint_if bus_a ();
  clint_if bus_b ();

  logic        msip_a, mtip_a, msip_b, mtip_b;
  logic [63:0] mtime_a, mtime_b;

  clint #(.RTC_DIV(1)) dut_a (
    .reset(reset), .clock(clock), .bus(bus_a),
    .msip(msip_a), .mtip(mtip_a), .mtime(mtime_a)
  );

  clint #(.RTC_DIV(4), .BASE_MASK(32'h0000_FFFF)) dut_b (
    .reset(reset), .clock(clock), .bus(bus_b),
    .msip(msip_b), .mtip(mtip_b), .mtime(mtime_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Register-level model of the RTC_DIV=1 instance.
  logic [63:0] m_time, m_cmp;
  logic        m_msip, m_mtip, m_ready;
  logic [31:0] m_rdata;
  int unsigned n_b;
  bit          live = 1'b0;

  function automatic logic [31:0] merge_bytes(input logic [31:0] o, input logic [31:0] n,
                                              input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (s[i]) r[i*8 +: 8] = n[i*8 +: 8];
    return r;
  endfunction

  always @(posedge clock) begin : model
    logic [63:0] pt, pc;
    logic [31:0] off, rd;
    bit          wrote;
    if (!reset) begin
      m_time = 64'h0; m_cmp = '1; m_msip = 1'b0; m_mtip = 1'b0;
      m_ready = 1'b0; m_rdata = 32'h0; n_b = 0;
    end else begin
      pt = m_time; pc = m_cmp; wrote = 1'b0; rd = 32'h0;
      off = bus_a.clint_addr & 32'h0000_FFFF;
      if (bus_a.clint_valid) begin
        case (off)
          32'h0000: rd = {31'b0, m_msip};
          32'h4000: rd = pc[31:0];
          32'h4004: rd = pc[63:32];
          32'hBFF8: rd = pt[31:0];
          32'hBFFC: rd = pt[63:32];
          default:  rd = 32'h0;
        endcase
        if (!bus_a.clint_instr && bus_a.clint_wstrb != 4'b0) begin
          case (off)
            32'h0000: if (bus_a.clint_wstrb[0]) m_msip = bus_a.clint_wdata[0];
            32'h4000: m_cmp[31:0]  = merge_bytes(pc[31:0], bus_a.clint_wdata, bus_a.clint_wstrb);
            32'h4004: m_cmp[63:32] = merge_bytes(pc[63:32], bus_a.clint_wdata, bus_a.clint_wstrb);
            32'hBFF8: begin
              m_time[31:0] = merge_bytes(pt[31:0], bus_a.clint_wdata, bus_a.clint_wstrb);
              wrote = 1'b1;
            end
            32'hBFFC: begin
              m_time[63:32] = merge_bytes(pt[63:32], bus_a.clint_wdata, bus_a.clint_wstrb);
              wrote = 1'b1;
            end
            default: ;
          endcase
        end
      end
      m_ready = bus_a.clint_valid;
      m_rdata = bus_a.clint_valid ? rd : 32'h0;
      if (!wrote) m_time = pt + 64'd1;
      m_mtip = (pt >= pc);
      n_b++;
    end
    live = 1'b1;
  end

  always @(negedge clock) begin
    if (live) begin
      check("a_mtime", mtime_a, m_time);
      check("a_mtip", mtip_a, m_mtip);
      check("a_msip", msip_a, m_msip);
      check("a_ready", bus_a.clint_ready, m_ready);
      if (m_ready) check("a_rdata", bus_a.clint_rdata, m_rdata);
      check("b_mtime", mtime_b, 64'(n_b / 4));
      check("b_mtip", mtip_b, 1'b0);
      check("b_ready", bus_b.clint_ready, 1'b0);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, input bit instr);
    bus_a.clint_valid = 1'b1;
    bus_a.clint_instr = instr;
    bus_a.clint_addr  = addr;
    bus_a.clint_wdata = wdata;
    bus_a.clint_wstrb = wstrb;
  endtask

  task automatic idle();
    bus_a.clint_valid = 1'b0;
    bus_a.clint_instr = 1'b0;
    bus_a.clint_wstrb = 4'b0;
  endtask

  // One request, then the response one edge later; the strobe is left asserted
  // so a following xfer runs back-to-back.
  task automatic xfer(input string name, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] wstrb, input bit instr, input logic [31:0] exp);
    drive(addr, wdata, wstrb, instr);
    step();
    check({name, "_ready"}, bus_a.clint_ready, 1'b1);
    check(name, bus_a.clint_rdata, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          found;
    logic [31:0] pre_lo;
    idle();
    bus_a.clint_addr = 32'h0; bus_a.clint_wdata = 32'h0;
    bus_b.clint_valid = 1'b0; bus_b.clint_instr = 1'b0; bus_b.clint_addr = 32'h0;
    bus_b.clint_wdata = 32'h0; bus_b.clint_wstrb = 4'b0;

    reset = 1'b0;
    repeat (3) step();
    check("rst_mtime", mtime_a, 64'h0);
    check("rst_mtip", mtip_a, 1'b0);
    check("rst_msip", msip_a, 1'b0);
    check("rst_ready", bus_a.clint_ready, 1'b0);
    check("rst_rdata", bus_a.clint_rdata, 32'h0);

    reset = 1'b1;
    check("rel_mtime0", mtime_a, 64'd0);
    step();
    check("rel_mtime1", mtime_a, 64'd1);
    step();
    check("rel_mtime2", mtime_a, 64'd2);
    check("rel_mtip", mtip_a, 1'b0);

    xfer("rd_mtime", 32'h0200_BFF8, 32'h0, 4'b0, 1'b0, 32'd2);
    xfer("rd_unmap", 32'h0000_1234, 32'h0, 4'b0, 1'b0, 32'h0);
    xfer("rd_cmph",  32'h0000_4004, 32'h0, 4'b0, 1'b0, 32'hFFFF_FFFF);
    idle();
    step();
    check("ready_drop", bus_a.clint_ready, 1'b0);

    xfer("fetch_msip", 32'h0, 32'h1, 4'hF, 1'b1, 32'h0);
    idle();
    check("fetch_nowr", msip_a, 1'b0);

    xfer("cmp_lo", 32'h4000, 32'h20, 4'hF, 1'b0, 32'hFFFF_FFFF);
    xfer("cmp_hi", 32'h4004, 32'h0,  4'hF, 1'b0, 32'hFFFF_FFFF);
    idle();
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (mtime_a == 64'h20) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check("cmp_reach", found, 1'b1);
    check("mtip_pre", mtip_a, 1'b0);
    step();
    check("mtip_rise", mtip_a, 1'b1);

    while (n_b < 40) step();
    check("b_div4_40", mtime_b, 64'd10);

    xfer("cmph_one", 32'h4004, 32'h1, 4'hF, 1'b0, 32'h0);
    idle();
    check("mtip_hold", mtip_a, 1'b1);
    step();
    check("mtip_fall", mtip_a, 1'b0);

    pre_lo = m_time[31:0];
    xfer("mt_lo", 32'hBFF8, 32'hFFFF_FFFF, 4'hF, 1'b0, pre_lo);
    xfer("mt_hi", 32'hBFFC, 32'h0,         4'hF, 1'b0, 32'h0);
    idle();
    check("mt_noinc", mtime_a, 64'h0000_0000_FFFF_FFFF);
    step();
    check("mt_carry", mtime_a, 64'h0000_0001_0000_0000);

    xfer("mt_lo1", 32'hBFF8, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0);
    xfer("mt_hi1", 32'hBFFC, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h1);
    idle();
    check("mt_ones", mtime_a, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    check("mt_wrap", mtime_a, 64'h0);

    xfer("cmp_bytes", 32'h4000, 32'hAABB_CCDD, 4'b0101, 1'b0, 32'h20);
    xfer("cmp_rdbk",  32'h4000, 32'h0,         4'b0,    1'b0, 32'h00BB_00DD);

    xfer("msip_wr",  32'h0, 32'h3, 4'b0001, 1'b0, 32'h0);
    xfer("msip_rd",  32'h0, 32'h0, 4'b0,    1'b0, 32'h1);
    idle();
    check("msip_set", msip_a, 1'b1);
    xfer("msip_clr", 32'h0, 32'h0, 4'hF,    1'b0, 32'h1);
    idle();
    check("msip_low", msip_a, 1'b0);

    xfer("unmap_wr", 32'h2000, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0);
    idle();

    drive(32'h0, 32'h1, 4'hF, 1'b0);
    reset = 1'b0;
    step();
    check("rstreq_msip", msip_a, 1'b0);
    check("rstreq_ready", bus_a.clint_ready, 1'b0);
    check("rstreq_mtime", mtime_a, 64'h0);
    idle();
    reset = 1'b1;
    step();
    check("post_msip", msip_a, 1'b0);
    check("post_mtime", mtime_a, 64'd1);
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
